// File: rtl/red_pitaya_acq_ch_multi_seg.sv
// red_pitaya_acq_ch_multi_seg
//   Segmented ADC acquisition channel. After an arm, each of up to N_SEG
//   segments waits for its own trigger, then decimates adc_dat_i and stores
//   a per-segment number of samples contiguously in one channel RAM.
//
// Optional feature (compile-time macro ACQ_AVG_EN):
//   defined   - each stored sample is the mean over its decimation window
//               (31-bit accumulator, sum >>> floor(log2(D)), exact for 2^n D)
//   undefined - first sample of each decimation window is stored
//
// Ports:
//   adc_clk_i, adc_rst_i        sole clock, synchronous active-high reset
//   adc_dat_i                   signed 14-bit ADC sample
//   trig_sw_i, trig_ext_i       software pulse / asynchronous external trigger
//   trig_src_i                  1 sw, 2 ext rising, 3 ext falling, else none
//   set_arm_i, set_rst_i        arm (restart at segment 0) / abort to idle
//   set_nseg_i                  segment count minus 1
//   set_dec_all_i               17-bit decimation per segment (0 acts as 1)
//   set_len_all_i               RSZ-bit samples-minus-1 per segment
//   buf_addr_i, buf_rdata_o     read-back port, 1-cycle latency
//   buf_wpnt_o, seg_cnt_o       next write address, current segment
//   busy_o, seg_done_o,
//   acq_done_o, ovf_o           status: busy, segment/acquisition pulses,
//                               sticky write-pointer wrap flag
module red_pitaya_acq_ch_multi_seg #(
  parameter int unsigned RSZ   = 14,
  parameter int unsigned N_SEG = 4
) (
  input  logic                       adc_clk_i,
  input  logic                       adc_rst_i,
  input  logic [13:0]                adc_dat_i,
  input  logic                       trig_sw_i,
  input  logic                       trig_ext_i,
  input  logic [2:0]                 trig_src_i,
  input  logic                       set_arm_i,
  input  logic                       set_rst_i,
  input  logic [$clog2(N_SEG)-1:0]   set_nseg_i,
  input  logic [17*N_SEG-1:0]        set_dec_all_i,
  input  logic [RSZ*N_SEG-1:0]       set_len_all_i,
  input  logic [RSZ-1:0]             buf_addr_i,
  output logic [13:0]                buf_rdata_o,
  output logic [RSZ-1:0]             buf_wpnt_o,
  output logic [$clog2(N_SEG)-1:0]   seg_cnt_o,
  output logic                       busy_o,
  output logic                       seg_done_o,
  output logic                       acq_done_o,
  output logic                       ovf_o
);
  localparam int unsigned SW      = $clog2(N_SEG);
  localparam logic [15:0] DEB_LEN = 16'd62500;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_NEXT_SEG, S_DONE
  } state_t;

  // ---------------- trigger path ----------------
  // ext_sync_q[1:0] is the synchronizer, ext_sync_q[2] the previous
  // synchronized level for edge detection.
  logic [2:0]  ext_sync_q, ext_sync_d;
  logic [15:0] deb_p_q, deb_p_d, deb_n_q, deb_n_d;
  logic        ext_p_q, ext_p_d, ext_n_q, ext_n_d;
  logic        trig_in_q, trig_in_d;
  logic        trig_sel;

  always_comb begin
    ext_sync_d = {ext_sync_q[1:0], trig_ext_i};
    // An edge is accepted only when its lockout counter has expired.
    ext_p_d = 1'b0;
    deb_p_d = deb_p_q;
    if (ext_sync_q[1] && !ext_sync_q[2] && (deb_p_q == '0)) begin
      ext_p_d = 1'b1;
      deb_p_d = DEB_LEN;
    end else if (deb_p_q != '0) begin
      deb_p_d = deb_p_q - 16'd1;
    end
    ext_n_d = 1'b0;
    deb_n_d = deb_n_q;
    if (!ext_sync_q[1] && ext_sync_q[2] && (deb_n_q == '0)) begin
      ext_n_d = 1'b1;
      deb_n_d = DEB_LEN;
    end else if (deb_n_q != '0) begin
      deb_n_d = deb_n_q - 16'd1;
    end
    case (trig_src_i)
      3'd1:    trig_sel = trig_sw_i;
      3'd2:    trig_sel = ext_p_q;
      3'd3:    trig_sel = ext_n_q;
      default: trig_sel = 1'b0;
    endcase
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      ext_sync_q <= '0;
      deb_p_q    <= '0;
      deb_n_q    <= '0;
      ext_p_q    <= 1'b0;
      ext_n_q    <= 1'b0;
    end else begin
      ext_sync_q <= ext_sync_d;
      deb_p_q    <= deb_p_d;
      deb_n_q    <= deb_n_d;
      ext_p_q    <= ext_p_d;
      ext_n_q    <= ext_n_d;
    end
  end

  // ---------------- acquisition FSM ----------------
  state_t          state_q, state_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic [RSZ-1:0]  wpnt_q, wpnt_d;
  logic [RSZ-1:0]  smp_cnt_q, smp_cnt_d;
  logic [16:0]     dec_cnt_q, dec_cnt_d;
  logic [13:0]     smp_q, smp_d;
  logic            wr_q, wr_d;
  logic            ovf_q, ovf_d;
  logic            we;
  logic [16:0]     dec_cur, d_eff;
  logic [RSZ-1:0]  len_cur;
  logic            dec_last;
`ifdef ACQ_AVG_EN
  logic signed [30:0] acc_q, acc_d, acc_sum;
  logic [4:0]         sh;
`endif

  always_comb begin
    dec_cur  = set_dec_all_i[17*seg_q +: 17];
    len_cur  = set_len_all_i[RSZ*seg_q +: RSZ];
    d_eff    = (dec_cur == '0) ? 17'd1 : dec_cur;
    dec_last = (dec_cnt_q == d_eff - 17'd1);

    // Triggers only count while waiting in ARMED; an arm or abort in the
    // same cycle wins, so a coincident trigger is dropped.
    trig_in_d = trig_sel && (state_q == S_ARMED) && !set_arm_i && !set_rst_i;

    state_d   = state_q;
    seg_d     = seg_q;
    wpnt_d    = wpnt_q;
    smp_cnt_d = smp_cnt_q;
    dec_cnt_d = dec_cnt_q;
    smp_d     = smp_q;
    wr_d      = 1'b0;
    ovf_d     = ovf_q;
    we        = 1'b0;
`ifdef ACQ_AVG_EN
    acc_d   = acc_q;
    acc_sum = '0;
    sh      = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      if (d_eff[i]) sh = 5'(i);
    end
`endif

    case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        if (trig_in_q) begin
          state_d   = S_CAPTURE;
          dec_cnt_d = '0;
          smp_cnt_d = '0;
`ifdef ACQ_AVG_EN
          acc_d = '0;
`endif
        end
      end
      S_CAPTURE: begin
        dec_cnt_d = dec_last ? '0 : dec_cnt_q + 17'd1;
`ifdef ACQ_AVG_EN
        acc_sum = ((dec_cnt_q == '0) ? 31'sd0 : acc_q)
                + {{17{adc_dat_i[13]}}, adc_dat_i};
        acc_d   = acc_sum;
        if (dec_last) begin
          smp_d = 14'(acc_sum >>> sh);
          wr_d  = 1'b1;
        end
`else
        if (dec_cnt_q == '0) begin
          smp_d = adc_dat_i;
          wr_d  = 1'b1;
        end
`endif
        // The write of the previous cycle's sample; a sample taken in the
        // cycle of the final write is discarded.
        if (wr_q) begin
          we        = 1'b1;
          wpnt_d    = wpnt_q + 1'b1;
          smp_cnt_d = smp_cnt_q + 1'b1;
          if (wpnt_q == '1) ovf_d = 1'b1;
          if (smp_cnt_q == len_cur) begin
            wr_d    = 1'b0;
            state_d = (seg_q == set_nseg_i) ? S_DONE : S_NEXT_SEG;
          end
        end
      end
      S_NEXT_SEG: begin
        seg_d   = seg_q + 1'b1;
        state_d = S_ARMED;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (set_arm_i) begin
      state_d = S_ARMED;
      seg_d   = '0;
      wpnt_d  = '0;
      ovf_d   = 1'b0;
      wr_d    = 1'b0;
      we      = 1'b0;
    end
    if (adc_rst_i || set_rst_i) we = 1'b0;
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i || set_rst_i) begin
      state_q   <= S_IDLE;
      seg_q     <= '0;
      wpnt_q    <= '0;
      smp_cnt_q <= '0;
      dec_cnt_q <= '0;
      smp_q     <= '0;
      wr_q      <= 1'b0;
      ovf_q     <= 1'b0;
      trig_in_q <= 1'b0;
`ifdef ACQ_AVG_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      wpnt_q    <= wpnt_d;
      smp_cnt_q <= smp_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      smp_q     <= smp_d;
      wr_q      <= wr_d;
      ovf_q     <= ovf_d;
      trig_in_q <= trig_in_d;
`ifdef ACQ_AVG_EN
      acc_q     <= acc_d;
`endif
    end
  end

  // ---------------- channel RAM ----------------
  logic [13:0] mem [2**RSZ];
  logic [13:0] buf_rdata_q;

  always_ff @(posedge adc_clk_i) begin
    if (we) mem[wpnt_q] <= smp_q;
    buf_rdata_q <= mem[buf_addr_i];
  end

  assign buf_rdata_o = buf_rdata_q;
  assign buf_wpnt_o  = wpnt_q;
  assign seg_cnt_o   = seg_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                       (state_q == S_NEXT_SEG);
  assign seg_done_o  = (state_q == S_NEXT_SEG);
  assign acq_done_o  = (state_q == S_DONE);

endmodule

// File: doc/red_pitaya_acq_ch_multi_seg.md
Name: red_pitaya_acq_ch_multi_seg

Overview:
- Segmented ADC acquisition channel: capture side counterpart of the multi-buffer ASG channel.
- After an arm, each of up to N_SEG segments waits for its own trigger.
- On trigger, the segment decimates ADC samples and stores a per-segment number of samples, contiguously, in one channel RAM.
- Software reads the RAM back through a dual-port read port; status pulses feed the interrupt/sequencing logic.

Parameters:
RSZ, 14, RAM address width (2^RSZ samples of 14 bits)
N_SEG, 4, max segments; per-segment config buses are packed N_SEG-wide, segment k at slice k

Ports:
adc_clk_i  in  1  ADC clock, sole clock
adc_rst_i  in  1  synchronous active-high reset
adc_dat_i  in  14  signed ADC sample
trig_sw_i  in  1  software trigger pulse
trig_ext_i  in  1  external trigger, asynchronous
trig_src_i  in  3  1 = sw, 2 = ext rising, 3 = ext falling, others = none
set_arm_i  in  1  arm pulse; starts acquisition at segment 0
set_rst_i  in  1  abort to IDLE, synchronous
set_nseg_i  in  $clog2(N_SEG)  segment count minus 1
set_dec_all_i  in  17*N_SEG  decimation D per segment; 0 is treated as 1
set_len_all_i  in  RSZ*N_SEG  samples per segment minus 1
buf_addr_i  in  RSZ  read-back address
buf_rdata_o  out  14  read-back data, 1-cycle latency
buf_wpnt_o  out  RSZ  next write address
seg_cnt_o  out  $clog2(N_SEG)  current segment index
busy_o  out  1  high in ARMED/CAPTURE/NEXT_SEG
seg_done_o  out  1  1-cycle pulse at end of each non-final segment
acq_done_o  out  1  1-cycle pulse at end of final segment
ovf_o  out  1  sticky; write pointer wrapped during this acquisition

Behaviour:
- Reset (adc_rst_i or set_rst_i):
  - State IDLE; pointers, counters and accumulator cleared.
  - All outputs 0, except buf_rdata_o, which continues to track the RAM.
  - adc_rst_i also clears the trigger synchronizer and debounce; set_rst_i does not.
  - Reset has priority over arm and trigger in the same cycle.
- Trigger path:
  - trig_ext_i passes through a 2-FF synchronizer, then a 62500-cycle debounce on each edge.
  - The selected trigger is registered once into trig_in.
- FSM:
  - IDLE: set_arm_i -> ARMED; seg=0, wpnt=0, ovf=0.
  - ARMED: trig_in -> CAPTURE; dec_cnt=0, smp_cnt=0. Trigger pulses outside ARMED are ignored and not latched.
  - CAPTURE: see sample rules below.
  - NEXT_SEG: one cycle; seg_done_o=1; seg+1; -> ARMED.
  - DONE: one cycle; acq_done_o=1; -> IDLE.
  - set_arm_i in any non-IDLE state aborts and restarts at ARMED, seg 0, wpnt 0.
- CAPTURE sample rules (D = set_dec of the current segment; L = set_len of the current segment):
  - The sample taken is adc_dat_i in the cycle dec_cnt==0.
  - dec_cnt counts 0..D-1 and wraps.
  - Write happens one cycle after the sample is taken, to buf[wpnt]; then wpnt+1 and smp_cnt+1.
  - After the write with smp_cnt==L: if seg==set_nseg_i -> DONE, else -> NEXT_SEG.
  - The next segment starts at the following wpnt; there is no gap and no realignment.
- Latency: a trigger at cycle t gives trig_in at t+1, CAPTURE at t+2, first sample adc_dat_i@t+2, first RAM write at t+3.
- Wrap: wpnt is modulo 2^RSZ. Wrapping from 2^RSZ-1 to 0 sets ovf_o. ovf_o stays set until the next arm or reset.
- Config handling: config is sampled live via the current segment's slice. Software must hold config stable while busy_o is high.
- Read-back: reading the address being written in the same cycle returns the old data.

Optional Feature:
ACQ_AVG_EN
- Defined:
  - Each stored sample is the mean over its decimation window.
  - A 31-bit signed accumulator sums D samples.
  - Stored value is sum >>> floor(log2(D)), truncated to 14 bits. Exact only for power-of-two D; this is documented, not flagged.
  - Write occurs the cycle after the window's last sample, so first-write latency becomes t+2+D.
- Undefined: first-sample-of-window decimation as described in Behaviour, with no accumulator.

Test Plan:
- nseg=0, D=1, L=7, sw trigger at cycle 10, adc_dat_i = cycle count -> buf[0..7] = 12..19, acq_done_o at cycle 21, seg_done_o never.
- nseg=2, L=3 each, D=1/2/4, three ext rising triggers -> segments at addresses 0-3, 4-7, 8-11; sample spacing 1/2/4; seg_done_o twice, then acq_done_o; seg_cnt_o steps 0,1,2.
- Ext trigger glitch train: rising edges 100 cycles apart -> only the first edge triggers.
- Wrap: RSZ=4, nseg=1, L=11 each -> 24 writes; addresses 0-7 hold segment-1 data written over segment 0; ovf_o=1.
- Abort: set_rst_i mid-CAPTURE -> IDLE the next cycle, busy_o=0, no done pulses. set_arm_i with a trigger in the same cycle while in IDLE -> ARMED, and that trigger is ignored.
- ACQ_AVG_EN: D=4, input cycling 0,4,8,12 -> every stored sample = 6.
